// File: rtl/ro_multich_freq_meter_pkg.sv
// Shared definitions for the multi-channel ring-oscillator frequency meter:
// FSM state encoding and the fixed warm-up / settle phase lengths.
`timescale 1ns/1ps
package ro_multich_freq_meter_pkg;

  localparam int unsigned ClearCyc  = 4;
  localparam int unsigned SettleCyc = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StSample,
    StDone
  } meter_state_e;

endpackage

// File: rtl/ro_edge_counter.sv
// Saturating rising-edge counter clocked by the selected oscillator.
// Clear and enable come from clk1-domain flops and are stable while it counts.
`timescale 1ns/1ps
module ro_edge_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ro_multich_freq_meter.sv
// Multi-channel RO frequency meter: gated edge counting over WIN_LEN clk1 cycles,
// 2**AVG_LOG2 windows summed per result, single-channel or round-robin scan.
`timescale 1ns/1ps
module ro_multich_freq_meter import ro_multich_freq_meter_pkg::*; #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CW       = 16,
  parameter int unsigned WIN_LEN  = 10000,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned CHW      = $clog2(NCH)
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         i_osc_in,
  output logic [NCH-1:0]         o_osc_en,
  input  logic                   i_run,
  input  logic                   i_scan_mode,
  input  logic [CHW-1:0]         i_ch_sel,
  output logic                   o_busy,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [CHW-1:0]         o_res_ch,
  output logic [CW+AVG_LOG2-1:0] o_res_sum,
  output logic [CW-1:0]          o_res_avg,
  output logic                   o_res_sat
);

  localparam int unsigned AccW = CW + AVG_LOG2;
  localparam int unsigned IdxW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned PhW  = $clog2(WIN_LEN + ClearCyc + SettleCyc);
  localparam logic [IdxW-1:0] LastIdx = IdxW'((1 << AVG_LOG2) - 1);
  localparam logic [CHW-1:0]  LastCh  = CHW'(NCH - 1);
  localparam logic [CW-1:0]   CntMax  = '1;

  function automatic logic [CHW-1:0] map_ch(input logic [CHW-1:0] sel);
    return (32'(sel) >= NCH) ? '0 : sel;
  endfunction

  meter_state_e    r_state, w_state_d;
  logic [PhW-1:0]  r_cyc, w_cyc_d;
  logic [IdxW-1:0] r_idx, w_idx_d;
  logic [AccW-1:0] r_acc, w_acc_d;
  logic            r_sat, w_sat_d;
  logic [CHW-1:0]  r_ch, w_ch_d;
  logic            r_res_valid, w_res_valid_d;
  logic [CHW-1:0]  r_res_ch, w_res_ch_d;
  logic [AccW-1:0] r_res_sum, w_res_sum_d;
  logic            r_res_sat, w_res_sat_d;
  logic            r_gate, r_cnt_clr;
  logic            w_measuring;
  logic            w_osc_clk;
  logic [CW-1:0]   w_count;

  assign w_measuring = r_state inside {StClear, StGate, StSettle, StSample};
  assign w_osc_clk   = i_osc_in[r_ch];

  ro_edge_counter #(
    .CW (CW)
  ) u_edge_counter (
    .i_clk   (w_osc_clk),
    .i_clr   (r_cnt_clr),
    .i_en    (r_gate),
    .o_count (w_count)
  );

  always_comb begin
    w_state_d     = r_state;
    w_cyc_d       = r_cyc + 1'b1;
    w_idx_d       = r_idx;
    w_acc_d       = r_acc;
    w_sat_d       = r_sat;
    w_ch_d        = r_ch;
    w_res_valid_d = r_res_valid;
    w_res_ch_d    = r_res_ch;
    w_res_sum_d   = r_res_sum;
    w_res_sat_d   = r_res_sat;

    if (w_measuring && !i_run) begin
      // Abort: the partial accumulation is discarded.
      w_state_d = StIdle;
      w_cyc_d   = '0;
      w_idx_d   = '0;
      w_acc_d   = '0;
      w_sat_d   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_cyc_d = '0;
          if (i_run) begin
            w_ch_d    = i_scan_mode ? '0 : map_ch(i_ch_sel);
            w_state_d = StClear;
          end
        end
        StClear: begin
          if (r_cyc == PhW'(ClearCyc - 1)) begin
            w_cyc_d   = '0;
            w_state_d = StGate;
          end
        end
        StGate: begin
          if (r_cyc == PhW'(WIN_LEN - 1)) begin
            w_cyc_d   = '0;
            w_state_d = StSettle;
          end
        end
        StSettle: begin
          if (r_cyc == PhW'(SettleCyc - 1)) begin
            w_cyc_d   = '0;
            w_state_d = StSample;
          end
        end
        StSample: begin
          w_cyc_d = '0;
          w_acc_d = r_acc + AccW'(w_count);
          w_sat_d = r_sat | (w_count == CntMax);
          if (r_idx == LastIdx) begin
            w_state_d     = StDone;
            w_res_valid_d = 1'b1;
            w_res_ch_d    = r_ch;
            w_res_sum_d   = w_acc_d;
            w_res_sat_d   = w_sat_d;
          end else begin
            w_idx_d   = r_idx + 1'b1;
            w_state_d = StClear;
          end
        end
        StDone: begin
          // run is ignored here until the consumer takes the result.
          w_cyc_d = '0;
          if (i_res_ready) begin
            w_res_valid_d = 1'b0;
            w_acc_d       = '0;
            w_idx_d       = '0;
            w_sat_d       = 1'b0;
            if (i_scan_mode) begin
              w_ch_d = (r_ch == LastCh) ? '0 : r_ch + 1'b1;
            end else begin
              w_ch_d = map_ch(i_ch_sel);
            end
            w_state_d = i_run ? StClear : StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cyc       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_ch        <= '0;
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_sum   <= '0;
      r_res_sat   <= 1'b0;
      r_gate      <= 1'b0;
      r_cnt_clr   <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_cyc       <= w_cyc_d;
      r_idx       <= w_idx_d;
      r_acc       <= w_acc_d;
      r_sat       <= w_sat_d;
      r_ch        <= w_ch_d;
      r_res_valid <= w_res_valid_d;
      r_res_ch    <= w_res_ch_d;
      r_res_sum   <= w_res_sum_d;
      r_res_sat   <= w_res_sat_d;
      r_gate      <= (w_state_d == StGate);
      // Counter held clear whenever no window is in progress or warming up.
      r_cnt_clr   <= (w_state_d == StIdle) || (w_state_d == StClear);
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_osc_en    = w_measuring ? (NCH'(1) << r_ch) : '0;
  assign o_res_valid = r_res_valid;
  assign o_res_ch    = r_res_ch;
  assign o_res_sum   = r_res_sum;
  assign o_res_avg   = r_res_sum[AccW-1:AVG_LOG2];
  assign o_res_sat   = r_res_sat;

endmodule

// File: tb/tb_ro_multich_freq_meter.sv
// Bench for ro_multich_freq_meter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized run/ready/mode/reset traffic.
`timescale 1ns/1ps
module tb_ro_multich_freq_meter;

  localparam int unsigned NCH      = 3;
  localparam int unsigned CW       = 12;
  localparam int unsigned WIN_LEN  = 100;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned CHW      = 2;
  localparam int          NW       = 1 << AVG_LOG2;
  localparam int          L        = NW * (WIN_LEN + 9);
  localparam int          CNT_MAX  = (1 << CW) - 1;
  localparam real         CLK_NS   = 100.0;

  logic                   clk1, rst_n;
  logic                   osc0, osc1, osc2;
  logic [NCH-1:0]         osc_in;
  logic [NCH-1:0]         osc_en;
  logic                   run, scan_mode, busy, res_valid, res_ready, res_sat;
  logic [CHW-1:0]         ch_sel, res_ch;
  logic [CW+AVG_LOG2-1:0] res_sum;
  logic [CW-1:0]          res_avg;

  int n_checks = 0;
  int n_err    = 0;

  assign osc_in = {osc2, osc1, osc0};

  ro_multich_freq_meter #(
    .NCH      (NCH),
    .CW       (CW),
    .WIN_LEN  (WIN_LEN),
    .AVG_LOG2 (AVG_LOG2),
    .CHW      (CHW)
  ) u_dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .i_osc_in    (osc_in),
    .o_osc_en    (osc_en),
    .i_run       (run),
    .i_scan_mode (scan_mode),
    .i_ch_sel    (ch_sel),
    .o_busy      (busy),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_ch    (res_ch),
    .o_res_sum   (res_sum),
    .o_res_avg   (res_avg),
    .o_res_sat   (res_sat)
  );

  // Oscillator half periods in ns: 50, 100 and 500 MHz. The 0.3 ns offset keeps
  // every oscillator edge away from clk1 edges, so window counts are exact.
  function automatic real osc_half(input int ch);
    case (ch)
      0:       return 10.0;
      1:       return 5.0;
      default: return 1.0;
    endcase
  endfunction

  function automatic int raw_cnt(input int ch);
    return int'(real'(WIN_LEN) * CLK_NS / (2.0 * osc_half(ch)));
  endfunction

  function automatic int map_sel(input int sel);
    return (sel >= NCH) ? 0 : sel;
  endfunction

  initial begin clk1 = 1'b0; forever #50 clk1 = ~clk1; end
  initial begin osc0 = 1'b0; #0.3; forever #(osc_half(0)) osc0 = ~osc0; end
  initial begin osc1 = 1'b0; #0.3; forever #(osc_half(1)) osc1 = ~osc1; end
  initial begin osc2 = 1'b0; #0.3; forever #(osc_half(2)) osc2 = ~osc2; end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: Idle / Measuring (t = cycles into the result) / Done.
  typedef enum {MIdle, MMeas, MDone} mmode_e;
  mmode_e m_mode = MIdle;
  int     m_t    = 0;
  int     m_ch   = 0;
  int     m_rch  = 0;
  int     m_sum  = 0;
  int     m_sat  = 0;

  initial begin : cmp
    logic s_rst, s_run, s_scan, s_ready;
    logic [CHW-1:0] s_sel;
    int   w;
    forever begin
      @(posedge clk1);
      s_rst = rst_n; s_run = run; s_scan = scan_mode; s_ready = res_ready; s_sel = ch_sel;
      @(negedge clk1);
      if (!s_rst) begin
        m_mode = MIdle; m_ch = 0; m_t = 0;
      end else begin
        case (m_mode)
          MIdle: if (s_run) begin
            m_ch   = s_scan ? 0 : map_sel(int'(s_sel));
            m_mode = MMeas;
            m_t    = 0;
          end
          MMeas: begin
            if (!s_run) begin
              m_mode = MIdle;
            end else if (m_t == L - 1) begin
              w      = raw_cnt(m_ch);
              m_sat  = (w >= CNT_MAX) ? 1 : 0;
              m_sum  = NW * ((w > CNT_MAX) ? CNT_MAX : w);
              m_rch  = m_ch;
              m_mode = MDone;
            end else begin
              m_t++;
            end
          end
          default: if (s_ready) begin
            m_ch   = s_scan ? (m_ch + 1) % NCH : map_sel(int'(s_sel));
            m_mode = s_run ? MMeas : MIdle;
            m_t    = 0;
          end
        endcase
      end
      chk("busy", busy, (m_mode != MIdle));
      chk("osc_en", osc_en, (m_mode == MMeas) ? (1 << m_ch) : 0);
      chk("res_valid", res_valid, (m_mode == MDone));
      if (m_mode == MDone) begin
        chk("res_ch", res_ch, m_rch);
        chk("res_sum", res_sum, m_sum);
        chk("res_avg", res_avg, m_sum / NW);
        chk("res_sat", res_sat, m_sat);
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk({name, "_valid"}, res_valid, 1);
  endtask

  task automatic handshake(input logic run_after);
    res_ready = 1'b1;
    run       = run_after;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin : stim
    int cyc;
    int exp_avg [3];
    exp_avg = '{500, 1000, 4095};
    rst_n = 1'b0; run = 1'b0; scan_mode = 1'b0; ch_sel = '0; res_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_osc_en", osc_en, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);

    // Single mode on channel 1 (100 MHz).
    ch_sel = 2'd1; run = 1'b1;
    wait_valid("t1", cyc);
    chk("t1_latency", cyc, L + 1);
    chk("t1_ch", res_ch, 1);
    chk("t1_sum", res_sum, 4000);
    chk("t1_avg", res_avg, 1000);
    chk("t1_sat", res_sat, 0);
    handshake(1'b0);
    chk("t1_idle", busy, 0);

    // Backpressure, then ch_sel re-sampled at the handshake only.
    ch_sel = 2'd0; run = 1'b1;
    wait_valid("t3", cyc);
    repeat (500) tick();
    chk("t3_hold_sum", res_sum, 2000);
    chk("t3_hold_osc", osc_en, 0);
    chk("t3_hold_busy", busy, 1);
    ch_sel = 2'd2;
    handshake(1'b1);
    chk("t3_next_osc", osc_en, 3'b100);
    ch_sel = 2'd3;
    wait_valid("t6", cyc);
    chk("t6_ch", res_ch, 2);
    chk("t6_sum", res_sum, 16380);
    chk("t6_avg", res_avg, 4095);
    chk("t6_sat", res_sat, 1);
    handshake(1'b1);
    chk("t6_map_osc", osc_en, 3'b001);
    run = 1'b0;
    tick();

    // Round-robin scan with the consumer always ready.
    scan_mode = 1'b1; res_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("t2", cyc);
      chk("t2_ch", res_ch, i % NCH);
      chk("t2_avg", res_avg, exp_avg[i % NCH]);
      tick();
    end
    run = 1'b0; scan_mode = 1'b0; res_ready = 1'b0;
    repeat (2) tick();

    // Abort during the gate of the second window, then a full result.
    ch_sel = 2'd1; run = 1'b1;
    repeat (165) tick();
    run = 1'b0;
    tick();
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_valid", res_valid, 0);
    run = 1'b1;
    wait_valid("t4", cyc);
    chk("t4_latency", cyc, L + 1);
    chk("t4_sum", res_sum, 4000);
    handshake(1'b0);

    // Reset pulse during the settle phase of the first window.
    run = 1'b1;
    repeat (106) tick();
    rst_n = 1'b0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_osc", osc_en, 0);
    chk("t5_sum", res_sum, 0);
    rst_n = 1'b1;
    wait_valid("t5", cyc);
    chk("t5_latency", cyc, L + 1);
    chk("t5_res", res_sum, 4000);
    handshake(1'b0);

    // Randomized traffic; the per-cycle model carries the checking.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) ch_sel = CHW'($urandom_range(0, 3));
      res_ready = ($urandom_range(0, 3) != 0);
      if (run) begin
        if ($urandom_range(0, 399) == 0) run = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        run = 1'b1;
      end
      if ($urandom_range(0, 599) == 0) scan_mode = ~scan_mode;
      rst_n = ($urandom_range(0, 2499) != 0);
      tick();
    end
    rst_n = 1'b1; run = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
